// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU control slice.
// Contents:
//   alu_op_e        ALU operation codes 0..13 (0 = no operation / illegal)
//   state_e         sequencer FSM states
//   OPC_* / FN_*    instruction opcode and R-type func encodings
//   is_multicycle   true for operations that run in the HI/LO unit
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_XOR  = 4'd1,
    OP_OR   = 4'd2,
    OP_AND  = 4'd3,
    OP_NOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SLT  = 4'd7,
    OP_ADDU = 4'd8,
    OP_ADD  = 4'd9,
    OP_SUB  = 4'd10,
    OP_SUBU = 4'd11,
    OP_MULT = 4'd12,
    OP_DIV  = 4'd13
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Opcodes (instruction bits [31:26])
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;

  // R-type func codes (instruction bits [5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  function automatic logic is_multicycle(input alu_op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bundle between the ID stage (master) and the ALU op sequencer (slave).
// Handshake: the master presents an instruction with valid_in=1; it is taken
// on any rising edge where stall=0 and flush=0. While stall=1 the master must
// hold valid_in/opcode/func unchanged; the instruction is not consumed.
// flush=1 drops the in-flight operation and any instruction presented with it.
// Signals:
//   valid_in, opcode, func, flush    master -> slave
//   alu_operation, op_valid, stall,
//   done, hilo_we, illegal           slave -> master
//   dbg_state                        slave -> observer, current FSM state
interface alu_op_sequencer_if #(
  parameter int OP_W = 4
);
  import alu_ctrl_pkg::*;

  logic            valid_in;
  logic [5:0]      opcode;
  logic [5:0]      func;
  logic            flush;
  logic [OP_W-1:0] alu_operation;
  logic            op_valid;
  logic            stall;
  logic            done;
  logic            hilo_we;
  logic            illegal;
  state_e          dbg_state;

  modport master (
    output valid_in, opcode, func, flush,
    input  alu_operation, op_valid, stall, done, hilo_we, illegal, dbg_state
  );

  modport slave (
    input  valid_in, opcode, func, flush,
    output alu_operation, op_valid, stall, done, hilo_we, illegal, dbg_state
  );

endinterface

// File: rtl/alu_op_sequencer_decode.sv
// alu_op_decode: purely combinational opcode/func -> ALU operation decoder.
// Shared with the hazard unit, so it carries no state.
// Ports:
//   opcode  in   instruction [31:26]
//   func    in   instruction [5:0]
//   op      out  decoded operation (OP_NONE when not legal)
//   legal   out  1 when the encoding is recognised
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output alu_op_e    op,
  output logic       legal
);

  always_comb begin
    op    = OP_NONE;
    legal = 1'b1;
    if (opcode == OPC_RTYPE) begin
      case (func)
        FN_SLL, FN_SLLV: op = OP_SLL;
        FN_SRL, FN_SRLV: op = OP_SRL;
        FN_XOR:          op = OP_XOR;
        FN_SUB:          op = OP_SUB;
        FN_SLT:          op = OP_SLT;
        FN_SUBU:         op = OP_SUBU;
        FN_OR:           op = OP_OR;
        FN_NOR:          op = OP_NOR;
        FN_ADDU:         op = OP_ADDU;
        FN_MULT:         op = OP_MULT;
        FN_DIV:          op = OP_DIV;
        FN_AND:          op = OP_AND;
        FN_ADD:          op = OP_ADD;
        default:         legal = 1'b0;
      endcase
    end else begin
      case (opcode)
        OPC_XORI:             op = OP_XOR;
        OPC_SLTI:             op = OP_SLT;
        OPC_ADDI, OPC_ADDIU:  op = OP_ADDU;
        OPC_ANDI:             op = OP_AND;
        OPC_ORI:              op = OP_OR;
        default:              legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: registers the decoded ALU operation and sequences
// multi-cycle MULT/DIV with a stall toward the pipeline.
// Ports:
//   clk   in  rising-edge clock
//   rst   in  synchronous active-high reset
//   bus   alu_op_sequencer_if.slave (instruction in, ALU control out)
// Parameters:
//   OP_W         width of alu_operation (>= 4)
//   MULT_CYCLES  total EX latency of MULT (>= 2)
//   DIV_CYCLES   total EX latency of DIV (>= 2)
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W        = 4,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input logic clk,
  input logic rst,
  alu_op_sequencer_if.slave bus
);

  localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LAT);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  alu_op_e          op_q, op_d;
  logic             op_valid_q, op_valid_d;
  logic             illegal_q, illegal_d;

  alu_op_e dec_op;
  logic    dec_legal;

  alu_op_decode u_decode (
    .opcode (bus.opcode),
    .func   (bus.func),
    .op     (dec_op),
    .legal  (dec_legal)
  );

  logic busy, last, accept;
  // The final BUSY cycle (cnt = 0) accepts a new instruction just like IDLE,
  // which gives back-to-back issue without a bubble.
  assign busy   = (state_q == ST_BUSY);
  assign last   = busy && (cnt_q == '0);
  assign accept = bus.valid_in && !bus.flush && (!busy || last);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_NONE;
      op_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      op_valid_q <= op_valid_d;
      illegal_q  <= illegal_d;
    end
  end

  // Next state; defaults describe the quiet IDLE cycle, which is also the
  // flush outcome, so flush simply skips every other branch.
  always_comb begin
    state_d    = ST_IDLE;
    cnt_d      = '0;
    op_d       = OP_NONE;
    op_valid_d = 1'b0;
    illegal_d  = 1'b0;
    if (bus.flush) begin
      state_d = ST_IDLE;
    end else if (accept) begin
      if (!dec_legal) begin
        illegal_d = 1'b1;
      end else begin
        op_d       = dec_op;
        op_valid_d = 1'b1;
        if (is_multicycle(dec_op)) begin
          state_d = ST_BUSY;
          cnt_d   = (dec_op == OP_MULT) ? MULT_LOAD : DIV_LOAD;
        end
      end
    end else if (busy && !last) begin
      state_d    = ST_BUSY;
      cnt_d      = cnt_q - CNT_W'(1);
      op_d       = op_q;
      op_valid_d = 1'b1;
    end
  end

  // Outputs
  always_comb begin
    bus.alu_operation      = '0;
    bus.alu_operation[3:0] = op_q;
    bus.op_valid           = op_valid_q;
    bus.illegal            = illegal_q;
    bus.stall              = busy && (cnt_q != '0);
    // A flush or reset landing on the final cycle cancels the HI/LO write.
    bus.done               = last && !bus.flush && !rst;
    bus.hilo_we            = bus.done;
    bus.dbg_state          = state_q;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Parametrised successor to the single-cycle ALU control decoder. It decodes `opcode`/`func` into a registered ALU operation code and sequences multi-cycle operations (MULT, DIV) with a stall handshake toward the pipeline. It also flags undecodable instructions and supports a pipeline flush. It sits between the ID stage and the EX-stage ALU and HI/LO unit.

## Interface
- `OP_W`, 4: width of `alu_operation`; must be ≥ 4.
- `MULT_CYCLES`, 4: total EX latency of MULT; must be ≥ 2.
- `DIV_CYCLES`, 32: total EX latency of DIV; must be ≥ 2.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid_in`  in  1  instruction presented this cycle.
- `opcode`  in  6  instruction [31:26].
- `func`  in  6  instruction [5:0].
- `flush`  in  1  abort current and incoming operation.
- `alu_operation`  out  OP_W  registered ALU op code.
- `op_valid`  out  1  `alu_operation` is valid for the ALU this cycle.
- `stall`  out  1  upstream must hold its instruction.
- `done`  out  1  one-cycle pulse on the last cycle of MULT/DIV.
- `hilo_we`  out  1  HI/LO write enable; equal to `done`.
- `illegal`  out  1  one-cycle pulse: accepted instruction did not decode.

## Operation
- Decode map, R-type (`opcode` = 0, key is `func`):
  - SLL 00/SLLV 04 → 5; SRL 02/SRLV 06 → 6; XOR 26 → 1; SUB 22 → 10; SLT 2A → 7; SUBU 23 → 11.
  - OR 25 → 2; NOR 27 → 4; ADDU 21 → 8; MULT 18 → 12; DIV 1A → 13; AND 24 → 3; ADD 20 → 9.
  - All `func` values above are hex.
- Decode map, I-type (key is `opcode`): XORI 0E → 1; SLTI 0A → 7; ADDI 08 → 8; ANDI 0C → 3; ORI 0D → 2; ADDIU 09 → 8.
- Any other encoding is illegal. On an illegal instruction: `alu_operation` = 0, `op_valid` = 0, `illegal` = 1 for one cycle.
- Codes are zero-extended to `OP_W`.
- FSM states: IDLE, BUSY.
- IDLE:
  - An instruction is accepted when `valid_in` = 1 and `flush` = 0.
  - Single-cycle op: next cycle `alu_operation` = code, `op_valid` = 1; remain in IDLE.
  - MULT/DIV: load down-counter `cnt` = LAT−1 (LAT = `MULT_CYCLES` or `DIV_CYCLES`), go to BUSY, `alu_operation` = code.
- BUSY:
  - `op_valid` = 1 and `alu_operation` is held.
  - `cnt` decrements each cycle.
  - `stall` = (`cnt` ≠ 0), combinational from state.
  - When `cnt` = 0: `done` = `hilo_we` = 1, `stall` = 0. A `valid_in` in this same cycle is accepted exactly as in IDLE (back-to-back issue). Otherwise return to IDLE.
  - `valid_in` while `stall` = 1 is ignored; upstream holds the instruction.
- `flush`:
  - Next state is IDLE; `cnt` is cleared; no `done`/`hilo_we`.
  - Any same-cycle `valid_in` is dropped.
  - `flush` wins over every other event.
- Counter width is $clog2(max(`MULT_CYCLES`, `DIV_CYCLES`)). The counter never wraps: it is only loaded from IDLE or on the final BUSY cycle.

## Timing
- Reset values: `alu_operation` = 0, `op_valid` = 0, `stall` = 0, `done` = 0, `hilo_we` = 0, `illegal` = 0; state = IDLE; `cnt` = 0.
- Reset mid-BUSY: the next cycle is IDLE and no `done` is produced.
- Single-cycle op accepted at cycle N: `op_valid` at N+1 only.
- Illegal instruction at cycle N: `illegal` at N+1.
- MULT/DIV accepted at N:
  - BUSY for cycles N+1 … N+LAT.
  - `stall` = 1 during N+1 … N+LAT−1.
  - `done` at N+LAT.
  - Earliest next acceptance is N+LAT.
- Throughput: one single-cycle op per cycle; one multi-cycle op every LAT cycles.

## Structure
- `alu_ctrl_pkg`:
  - enum `alu_op_e` holding codes 0–13;
  - localparams for opcodes and funcs;
  - function `is_multicycle(alu_op_e)`.
- Sub-module `alu_op_decode`: purely combinational; outputs `op` and `legal`. It is reused by the hazard unit.
- `alu_op_sequencer` holds the FSM, counter and output registers.

## Test plan
- Reset then ADD (`opcode` 00, `func` 20) at N → `alu_operation` = 9, `op_valid` = 1 at N+1; `stall` = 0 throughout.
- MULT at N with default parameters → `stall` = 1 at N+1 … N+3; `done` = `hilo_we` = 1 at N+4; `alu_operation` = 12 for N+1 … N+4.
- DIV with back-to-back ORI (`opcode` 0D) presented and held → ORI accepted at N+32; `alu_operation` = 2 at N+33; exactly one `done`.
- `opcode` 3F → `illegal` pulse one cycle later, `alu_operation` = 0; then ADDIU (`opcode` 09) → 8.
- `flush` at N+2 of a DIV, with concurrent `valid_in` of XOR → IDLE at N+3, no `done`, XOR dropped.
- `rst` asserted mid-MULT → all outputs 0 next cycle; next SUBU (`func` 23) → 11.
